// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the ALU issue/writeback stage.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int  SEL_W      = 4;
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/alu_issue_regfile.sv
// Operand register file: two operand read ports, one host read port, host and writeback write ports.
// Combinational reads; writes land on the clock edge, with writeback beating host on the same register.
module alu_issue_regfile #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data
);

    logic [WIDTH-1:0] regs [NREGS];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];
    assign rd_data = regs[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en && wb_addr == ADDR_W'(i)) begin
                    regs[i] <= wb_data;
                end else if (wr_en && wr_addr == ADDR_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues register-file operands to a combinational ALU and writes the result back; accept-to-writeback is 2 edges.
// One command per 3 cycles: cmd_ready is high only in IDLE and never depends on cmd_valid.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_select,
    input  logic              cmd_mode,
    input  logic              cmd_use_c,
    input  logic [ADDR_W-1:0] cmd_srca,
    input  logic [ADDR_W-1:0] cmd_srcb,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [SEL_W-1:0]  alu_select,
    output logic              alu_mode,
    output logic              alu_carry_in,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry,
    input  logic              alu_compare,
    output logic              res_valid,
    output logic [WIDTH-1:0]  res_data,
    output logic [ADDR_W-1:0] res_dst,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_eq
);

    state_t            state;
    logic [ADDR_W-1:0] dst_q;
    logic [WIDTH-1:0]  ra_data;
    logic [WIDTH-1:0]  rb_data;
    logic              wb_en;

    assign wb_en = (state == WB);

    alu_issue_regfile #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (cmd_srca),
        .ra_data (ra_data),
        .rb_addr (cmd_srcb),
        .rb_data (rb_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wb_en   (wb_en),
        .wb_addr (dst_q),
        .wb_data (alu_result)
    );

    // Operands are captured at acceptance, so later host writes to sources cannot disturb the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_select   <= '0;
            alu_mode     <= 1'b0;
            alu_carry_in <= 1'b0;
            dst_q        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_dst      <= '0;
            flag_c       <= 1'b0;
            flag_z       <= 1'b0;
            flag_eq      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a        <= ra_data;
                        alu_b        <= rb_data;
                        alu_select   <= cmd_select;
                        alu_mode     <= cmd_mode;
                        alu_carry_in <= cmd_use_c & flag_c;
                        dst_q        <= cmd_dst;
                        cmd_ready    <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                WB: begin
                    flag_c    <= alu_carry;
                    flag_z    <= (alu_result == '0);
                    flag_eq   <= alu_compare;
                    res_data  <= alu_result;
                    res_dst   <= dst_q;
                    res_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-issue and writeback stage directly upstream of the team's 16-bit ALU.
- Holds a small operand register file and accepts ALU commands over a valid/ready handshake.
- Drives registered operands, select, mode and carry_in to the ALU, then captures the result and status flags back into the register file.
- Turns the purely combinational ALU into a sequenced, observable datapath.

Parameters:
- WIDTH, 16, datapath width; must match ALU operand width.
- NREGS, 4, number of operand registers; power of two, at least 2.
- ADDR_W, 2, register address width; equals clog2(NREGS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept a command
- cmd_select  in  4  ALU select code
- cmd_mode  in  1  ALU mode bit, passed through unchanged
- cmd_use_c  in  1  1: carry_in = flag_c; 0: carry_in = 0
- cmd_srca  in  ADDR_W  source register for A
- cmd_srcb  in  ADDR_W  source register for B
- cmd_dst  in  ADDR_W  destination register
- wr_en  in  1  host register write strobe
- wr_addr  in  ADDR_W  host write address
- wr_data  in  WIDTH  host write data
- rd_addr  in  ADDR_W  host read address
- rd_data  out  WIDTH  combinational read of regs[rd_addr]
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_select  out  4  registered select to ALU
- alu_mode  out  1  registered mode to ALU
- alu_carry_in  out  1  registered carry_in to ALU
- alu_result  in  WIDTH  ALU result
- alu_carry  in  1  ALU carry_out
- alu_compare  in  1  ALU equality output
- res_valid  out  1  one-cycle pulse: writeback happened
- res_data  out  WIDTH  value written in the writeback
- res_dst  out  ADDR_W  register written in the writeback
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- flag_eq  out  1  equality flag

Behaviour:
Reset:
- Asynchronous; may be asserted at any cycle, including mid-operation.
- State returns to IDLE and any in-flight command is dropped with no writeback.
- All registers, alu_a, alu_b, alu_select, res_data, res_dst = 0.
- alu_mode, alu_carry_in, res_valid, flag_c, flag_z, flag_eq = 0.
- cmd_ready = 1 from the first cycle after reset deasserts.

FSM has three states:
- IDLE: cmd_ready=1.
  - On cmd_valid, latch into the ALU-facing registers: alu_a=regs[srca], alu_b=regs[srcb], select, mode, carry_in (flag_c or 0), and dst.
  - Go to EXEC.
- EXEC: cmd_ready=0. ALU inputs are stable for the whole cycle. Go to WB.
- WB: cmd_ready=0.
  - Write regs[dst]=alu_result.
  - flag_c=alu_carry.
  - flag_z = (alu_result==0).
  - flag_eq=alu_compare.
  - res_data=alu_result, res_dst=dst; res_valid is high in the following cycle for exactly one cycle.
  - Go to IDLE.
- Operands are sampled at acceptance, so srca==srcb and dst==src are legal.

Timing:
- Throughput is one command per 3 cycles. Acceptance at edge N gives writeback at edge N+2 and res_valid high in cycle N+2..N+3.
- alu_* outputs hold their last values outside EXEC.
- cmd_ready depends only on state, never on cmd_valid.
- flag_z is computed over the full WIDTH.

Host writes and reads:
- A host write is accepted in every state.
- A host write to a source register during EXEC or WB does not affect the in-flight operands.
- If a host write and the WB write target the same register in the same cycle, the WB write wins. Different registers are both written.
- rd_data reflects writes from the cycle after the edge that performs them.

Decomposition:
- Package alu_issue_pkg holds:
  - state enum: IDLE, EXEC, WB;
  - localparams for the 4-bit select width and the mode encodings.
- One natural sub-module, alu_issue_regfile: NREGS x WIDTH storage with async reset, two combinational read ports plus the rd_addr port, host write port and WB write port with WB priority.
- FSM and the ALU-facing registers live in the top module.

Test Plan:
The bench instantiates this block wired to the team's 16-bit ALU.
1. Reset mid-EXEC -> cmd_ready=1 after release, res_valid never pulses, all registers read 0, all flags 0.
2. Host writes R0=0xFFFF, R1=0x0001; command select=1001 mode=0 src 0,1 dst 2 -> R2=0x0000, flag_c=1, flag_z=1, flag_eq=0. res_valid is a single pulse exactly 2 edges after acceptance.
3. R0=0x1234, R1=0x1234; mode=1 select=0110 (xor) dst 3 -> R3=0x0000, flag_eq=1, flag_z=1.
4. cmd_valid held high for 9 cycles with back-to-back commands -> exactly 3 accepted, cmd_ready pattern 1,0,0 repeating, no command lost or duplicated.
5. Host writes 0xAAAA to R2 in the same cycle as the WB to R2 -> R2 = ALU result. A host write to R0 during EXEC does not change that command's result.
6. flag_c=1, cmd_use_c=1 -> alu_carry_in=1 during EXEC. With cmd_use_c=0 -> alu_carry_in=0.
